// File: rtl/rf_pkg.sv
// Shared defaults and constants for the multi-port register file.
package rf_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_NUM_RD = 2;
  localparam int unsigned DEF_NUM_WR = 2;
  localparam int unsigned DEPTH      = 1 << DEF_ADDR_W;

  // Index of the hardwired zero register when ZERO_REG is enabled.
  localparam int unsigned ZERO_ADDR  = 0;

endpackage

// File: rtl/rf_if.sv
// Register-file bus: write ports, read ports and busy-set request.
interface rf_if
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = DEF_NUM_RD,
  parameter int unsigned NUM_WR = DEF_NUM_WR
);

  logic [NUM_WR-1:0]        RFWr;
  logic [NUM_WR*ADDR_W-1:0] WrAddr;
  logic [NUM_WR*DATA_W-1:0] WrData;
  logic [NUM_RD-1:0]        RdEn;
  logic [NUM_RD*ADDR_W-1:0] RdAddr;
  logic [NUM_RD*DATA_W-1:0] RdData;
  logic [NUM_RD-1:0]        RdBusy;
  logic                     SetBusy;
  logic [ADDR_W-1:0]        SetAddr;

  modport master (
    output RFWr, WrAddr, WrData, RdEn, RdAddr, SetBusy, SetAddr,
    input  RdData, RdBusy
  );

  modport slave (
    input  RFWr, WrAddr, WrData, RdEn, RdAddr, SetBusy, SetAddr,
    output RdData, RdBusy
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write flags with registered per-read-port lookup.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_WR   = DEF_NUM_WR,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_busy,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clears first, then the set, so a new producer supersedes a retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (wr_en[k]) busy_d[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (set_busy) busy_d[set_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[ADDR_W'(ZERO_ADDR)] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      rd_busy <= '0;
    end else begin
      busy_q <= busy_d;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        if (rd_en[i]) begin
          rd_busy[i] <= (BYPASS != 0) ? busy_d[rd_addr[i*ADDR_W +: ADDR_W]]
                                      : busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Multi-port register file: prioritised writes, optional write-to-read bypass,
// registered reads and an integrated busy scoreboard.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned NUM_WR   = DEF_NUM_WR,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic clk,
  input logic rst,
  rf_if.slave bus
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0]        mem_q [NREG];
  logic [NUM_WR-1:0]        wr_ok;
  logic [DATA_W-1:0]        rd_next [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic [NUM_RD-1:0]        rd_busy;

  // Writes that actually land; zero-register writes are dropped here so the
  // bypass path and the storage see the same set of writes.
  always_comb begin
    wr_ok = '0;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      wr_ok[k] = bus.RFWr[k] &&
                 !((ZERO_REG != 0) &&
                   (bus.WrAddr[k*ADDR_W +: ADDR_W] == ADDR_W'(ZERO_ADDR)));
    end
  end

  // Ascending port order: the last assignment (highest index) wins a conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_ok[k]) begin
          mem_q[bus.WrAddr[k*ADDR_W +: ADDR_W]] <= bus.WrData[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_next[i] = mem_q[bus.RdAddr[i*ADDR_W +: ADDR_W]];
      if (BYPASS != 0) begin
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (wr_ok[k] && (bus.WrAddr[k*ADDR_W +: ADDR_W] == bus.RdAddr[i*ADDR_W +: ADDR_W])) begin
            rd_next[i] = bus.WrData[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        if (bus.RdEn[i]) rd_data_q[i*DATA_W +: DATA_W] <= rd_next[i];
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_busy (bus.SetBusy),
    .set_addr (bus.SetAddr),
    .wr_en    (bus.RFWr),
    .wr_addr  (bus.WrAddr),
    .rd_en    (bus.RdEn),
    .rd_addr  (bus.RdAddr),
    .rd_busy  (rd_busy)
  );

  assign bus.RdData = rd_data_q;
  assign bus.RdBusy = rd_busy;

`ifdef RF_DEBUG
  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NREG; r++) $display("rf r%0d = %h", r, mem_q[r]);
  end
`endif

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: one instance with bypass and zero
// register, one without, both driven by the same stimulus.
module tb_rf_multiport;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  rfwr;
  logic [9:0]  wraddr;
  logic [63:0] wrdata;
  logic [1:0]  rden;
  logic [9:0]  rdaddr;
  logic        setbusy;
  logic [4:0]  setaddr;

  rf_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus0 ();
  rf_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus1 ();

  assign bus0.RFWr = rfwr;   assign bus1.RFWr = rfwr;
  assign bus0.WrAddr = wraddr; assign bus1.WrAddr = wraddr;
  assign bus0.WrData = wrdata; assign bus1.WrData = wrdata;
  assign bus0.RdEn = rden;   assign bus1.RdEn = rden;
  assign bus0.RdAddr = rdaddr; assign bus1.RdAddr = rdaddr;
  assign bus0.SetBusy = setbusy; assign bus1.SetBusy = setbusy;
  assign bus0.SetAddr = setaddr; assign bus1.SetAddr = setaddr;

  rf_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
                 .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );

  rf_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
                 .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );

  typedef struct {
    int unsigned tag;
    bit          inst;
    int unsigned port;
    logic [31:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: outputs are registered, so each expectation is tagged with the
  // edge after which it must hold and compared on the following falling edge.
  initial begin
    exp_t        e;
    logic [31:0] act_d;
    logic        act_b;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        e = sb.pop_front();
        if (e.tag != cyc) begin
          chk({e.name, "_stale"}, 64'(e.tag), 64'(cyc));
        end else begin
          act_d = e.inst ? bus1.RdData[e.port*32 +: 32] : bus0.RdData[e.port*32 +: 32];
          act_b = e.inst ? bus1.RdBusy[e.port] : bus0.RdBusy[e.port];
          chk({e.name, e.inst ? "_d1" : "_d0"}, 64'(act_d), 64'(e.data));
          chk({e.name, e.inst ? "_b1" : "_b0"}, 64'(act_b), 64'(e.busy));
        end
      end
    end
  end

  task automatic idle();
    rfwr = '0; wraddr = '0; wrdata = '0;
    rden = '0; rdaddr = '0; setbusy = 1'b0; setaddr = '0;
  endtask

  task automatic wr(input int unsigned p, input logic [4:0] a, input logic [31:0] d);
    rfwr[p] = 1'b1;
    wraddr[p*5 +: 5] = a;
    wrdata[p*32 +: 32] = d;
  endtask

  task automatic rd(input int unsigned p, input logic [4:0] a);
    rden[p] = 1'b1;
    rdaddr[p*5 +: 5] = a;
  endtask

  task automatic sb_push(input bit inst, input int unsigned p, input logic [31:0] d,
                         input logic b, input string nm);
    exp_t e;
    e.tag = cyc + 1; e.inst = inst; e.port = p; e.data = d; e.busy = b; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset mid-operation
    idle(); wr(0, 5, 32'hDEADBEEF); rd(0, 5);
    sb_push(0, 0, 32'hDEADBEEF, 1'b0, "r5_pre_rst");
    sb_push(1, 0, 32'h0,        1'b0, "r5_pre_rst");
    tick();
    #2 rst = 1'b1;
    idle(); wr(1, 6, 32'hAAAA5555); setbusy = 1'b1; setaddr = 5'd6;
    #1;
    chk("rst_data0", bus0.RdData, 64'h0);
    chk("rst_data1", bus1.RdData, 64'h0);
    chk("rst_busy", {bus1.RdBusy, bus0.RdBusy}, 64'h0);
    tick();
    rst = 1'b0;
    idle(); rd(0, 5); rd(1, 6);
    sb_push(0, 0, 32'h0, 1'b0, "r5_post_rst"); sb_push(1, 0, 32'h0, 1'b0, "r5_post_rst");
    sb_push(0, 1, 32'h0, 1'b0, "r6_lost");     sb_push(1, 1, 32'h0, 1'b0, "r6_lost");
    tick();

    // Dual write conflict
    idle(); wr(0, 7, 32'h11111111); wr(1, 7, 32'h22222222); rd(1, 7);
    sb_push(0, 1, 32'h22222222, 1'b0, "r7_conf_byp");
    sb_push(1, 1, 32'h0,        1'b0, "r7_conf_byp");
    tick();
    idle(); rd(0, 7);
    sb_push(0, 0, 32'h22222222, 1'b0, "r7_conf"); sb_push(1, 0, 32'h22222222, 1'b0, "r7_conf");
    tick();

    // Bypass
    idle(); wr(0, 3, 32'hCAFEF00D); rd(0, 3);
    sb_push(0, 0, 32'hCAFEF00D, 1'b0, "r3_same"); sb_push(1, 0, 32'h0, 1'b0, "r3_same");
    tick();
    idle(); rd(1, 3);
    sb_push(0, 1, 32'hCAFEF00D, 1'b0, "r3_next"); sb_push(1, 1, 32'hCAFEF00D, 1'b0, "r3_next");
    tick();

    // Zero register
    idle(); wr(1, 0, 32'hFFFFFFFF); setbusy = 1'b1; setaddr = 5'd0; rd(0, 0);
    sb_push(0, 0, 32'h0, 1'b0, "r0_same"); sb_push(1, 0, 32'h0, 1'b0, "r0_same");
    tick();
    idle(); rd(0, 0);
    sb_push(0, 0, 32'h0, 1'b0, "r0_next"); sb_push(1, 0, 32'hFFFFFFFF, 1'b1, "r0_next");
    tick();

    // Scoreboard set / clear / set-wins
    idle(); setbusy = 1'b1; setaddr = 5'd9; rd(0, 9);
    sb_push(0, 0, 32'h0, 1'b1, "r9_set"); sb_push(1, 0, 32'h0, 1'b0, "r9_set");
    tick();
    idle(); wr(0, 9, 32'h00000099); rd(1, 9);
    sb_push(0, 1, 32'h00000099, 1'b0, "r9_clr"); sb_push(1, 1, 32'h0, 1'b1, "r9_clr");
    tick();
    idle(); setbusy = 1'b1; setaddr = 5'd9; wr(1, 9, 32'h0000009A); rd(0, 9);
    sb_push(0, 0, 32'h0000009A, 1'b1, "r9_setclr"); sb_push(1, 0, 32'h00000099, 1'b0, "r9_setclr");
    tick();
    idle(); rd(1, 9);
    sb_push(0, 1, 32'h0000009A, 1'b1, "r9_after"); sb_push(1, 1, 32'h0000009A, 1'b1, "r9_after");
    tick();

    // RdEn hold
    idle(); wr(0, 4, 32'h00001234);
    tick();
    idle(); rd(0, 4);
    sb_push(0, 0, 32'h00001234, 1'b0, "r4_read"); sb_push(1, 0, 32'h00001234, 1'b0, "r4_read");
    tick();
    idle(); rdaddr[4:0] = 5'd4; wr(0, 4, 32'h00005678);
    sb_push(0, 0, 32'h00001234, 1'b0, "r4_hold_wr"); sb_push(1, 0, 32'h00001234, 1'b0, "r4_hold_wr");
    tick();
    idle(); rdaddr[4:0] = 5'd9;
    sb_push(0, 0, 32'h00001234, 1'b0, "r4_hold_addr"); sb_push(1, 0, 32'h00001234, 1'b0, "r4_hold_addr");
    tick();
    idle(); rd(0, 4);
    sb_push(0, 0, 32'h00005678, 1'b0, "r4_reread"); sb_push(1, 0, 32'h00005678, 1'b0, "r4_reread");
    tick();
    idle();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) chk("sb_drain", 64'(sb.size()), 64'h0);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
